// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential shifter family: default sizes,
// the controller state encoding and a small sizing helper.
package seq_shift_pkg;

    // Default operand width and shift-amount width (SHAMT_W = clog2(WIDTH)).
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    // Controller states. The fourth code (2'd3) is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bits needed for a counter that walks stages 0 .. numStages-1.
    // Never returns less than one bit so a single-stage build still has a counter.
    function automatic int stageWidth(input int numStages);
        int w;
        w = (numStages > 1) ? $clog2(numStages) : 1;
        return w;
    endfunction

endpackage

// File: rtl/seq_shift_left_stage.sv
// sl_stage: one fixed power-of-two stage of the left shifter.
// When enabled, it shifts left by the constant SHIFT with zero fill, or rotates
// left (MSBs re-enter at the LSB) when rot is high. When disabled, it passes
// the input through. Only constant shifts are used, so no barrel shifter is built.
module sl_stage
    import seq_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             rot,
    output logic [WIDTH-1:0] outp
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] wrapped;

    assign shifted = in << SHIFT;
    assign wrapped = in >> (WIDTH - SHIFT);

    // Select pass-through, zero-fill shift, or rotate for this stage.
    always_comb begin
        outp = in;
        if (en) begin
            if (rot) begin
                outp = shifted | wrapped;
            end else begin
                outp = shifted;
            end
        end
    end

endmodule

// File: rtl/seq_shift_left.sv
// seq_shift_left: multi-cycle logical left shifter.
// An operand is accepted on the in_valid/in_ready handshake. The shifter then
// runs SHAMT_W stages, one per clock (shift by 1, 2, 4, ...), each applied
// only when the matching bit of the shift amount is set, so the latency is
// fixed. The result is presented on the out_valid/out_ready handshake.
// Optional feature macro: SEQ_SL_ROTATE_EN adds the in_rot port. When this
// port is set, each active stage rotates instead of shifting.
module seq_shift_left
    import seq_shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
`ifdef SEQ_SL_ROTATE_EN
    input  logic               in_rot,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int STAGE_W = stageWidth(SHAMT_W);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

    state_e               state_q;
    state_e               state_d;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     acc_d;
    logic [SHAMT_W-1:0]   amt_q;
    logic [SHAMT_W-1:0]   amt_d;
    logic [STAGE_W-1:0]   stage_q;
    logic [STAGE_W-1:0]   stage_d;
    logic                 rotSel;

    logic [WIDTH-1:0]     stageOut [SHAMT_W];
    logic [WIDTH-1:0]     stageSel;

`ifdef SEQ_SL_ROTATE_EN
    logic rot_q;
    logic rot_d;

    // The rotate request is captured together with the operand and held for the whole operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    // Capture in_rot on the accept edge. Otherwise keep the current value.
    always_comb begin
        rot_d = rot_q;
        if (state_q == ST_IDLE && in_valid) begin
            rot_d = in_rot;
        end
    end

    assign rotSel = rot_q;
`else
    assign rotSel = 1'b0;
`endif

    // One fixed stage per shift-amount bit. Stage g moves the accumulator by 2**g.
    for (genvar g = 0; g < SHAMT_W; g++) begin : gStage
        sl_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << g)
        ) uStage (
            .in   (acc_q),
            .en   (amt_q[g]),
            .rot  (rotSel),
            .outp (stageOut[g])
        );
    end

    // Select the output of the stage that the counter points at this cycle.
    always_comb begin
        stageSel = acc_q;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (stage_q == STAGE_W'(i)) begin
                stageSel = stageOut[i];
            end
        end
    end

    // Controller state register. Reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, latched shift amount and stage counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            amt_q   <= '0;
            stage_q <= '0;
        end else begin
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
        end
    end

    // Next-state logic and datapath updates. The illegal state code falls back to IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    amt_d   = in_shamt;
                    stage_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = stageSel;
                stage_d = stage_q + STAGE_W'(1);
                if (stage_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs. The result is forced to zero outside DONE so a stale value never leaks.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = acc_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
